// File: rtl/dr_pkg.sv
// Shared dual-rail definitions: rail indices, spacer code, transmitter states
// and the single-bit codeword encoder.
package dr_pkg;

   localparam int RAIL_T   = 1;
   localparam int RAIL_F   = 0;
   localparam int RAIL_NUM = 2;

   localparam logic [RAIL_NUM-1:0] SPACER = 2'b00;

   typedef enum logic [1:0] {IDLE, DATA, NULL} dr_tx_state_e;

   function automatic logic [RAIL_NUM-1:0] dr_encode(input logic b);
      logic [RAIL_NUM-1:0] cw;
      cw         = SPACER;
      cw[RAIL_T] = b;
      cw[RAIL_F] = ~b;
      return cw;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage single-bit synchroniser, reset to 0; shared with the receive side.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (rst) sync_q <= '0;
      else     sync_q <= sync_d;
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dr_sync_tx.sv
// Valid/ready to four-phase return-to-spacer dual-rail transmitter.
//   state | meaning
//   IDLE  | link at spacer, may accept a word once ack_s is low
//   DATA  | codeword on the link, waiting for ack_s high
//   NULL  | spacer on the link, waiting for ack_s low
module dr_sync_tx
   import dr_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 1024
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [WIDTH-1:0]                    in_data,
   input  logic                                in_valid,
   output logic                                in_ready,
   output logic [WIDTH-1:0][RAIL_NUM-1:0]      out,
   input  logic                                ack,
   output logic                                busy,
   output logic                                err
);

   localparam int               CW        = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]    TO_MAX    = CW'(TIMEOUT);
   localparam logic [2:0]       HOLD_INIT = 3'(SYNC_STAGES);

   logic                             ack_s;
   logic                             accept;
   dr_tx_state_e                     state_q, state_d;
   logic [WIDTH-1:0][RAIL_NUM-1:0]   out_q, out_d;
   logic [CW-1:0]                    cnt_q, cnt_d;
   logic                             err_q, err_d;
   logic                             busy_q, busy_d;
   logic [2:0]                       hold_q, hold_d;

   sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d   (ack),
      .q   (ack_s)
   );

   // The synchroniser comes out of reset at 0 even if ack is stuck high, so
   // hold off acceptance until it has had time to fill with the real level.
   assign in_ready = (state_q == IDLE) && !ack_s && (hold_q == 3'd0);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      hold_d  = (hold_q != 3'd0) ? hold_q - 3'd1 : hold_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = DATA;
               for (int i = 0; i < WIDTH; i++) out_d[i] = dr_encode(in_data[i]);
            end
         end
         DATA: begin
            if (ack_s) begin
               state_d = NULL;
               for (int i = 0; i < WIDTH; i++) out_d[i] = SPACER;
            end
         end
         NULL: begin
            if (!ack_s) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            out_d   = '0;
         end
      endcase

      if (state_d != state_q || state_q == IDLE) cnt_d = '0;
      else if (cnt_q != TO_MAX)                   cnt_d = cnt_q + 1'b1;

      if (TIMEOUT != 0 && cnt_d == TO_MAX) err_d = 1'b1;

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         out_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         hold_q  <= HOLD_INIT;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         hold_q  <= hold_d;
      end
   end

   assign out  = out_q;
   assign busy = busy_q;
   assign err  = err_q;

endmodule

// File: tb/tb_dr_sync_tx.sv
// Directed bench for dr_sync_tx: vector table of words/codewords plus
// hand-written sequences for back-to-back, stale ack, timeout and reset.
module tb_dr_sync_tx;

   localparam int SYNC = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic [7:0][1:0]  dr_out;
   logic             ack;
   logic             busy;
   logic             err;

   logic             model_en = 1'b0;
   logic             ack_mdl  = 1'b0;
   logic             ack_man  = 1'b0;
   logic [15:0]      out_flat;

   int n_cmp = 0;
   int n_bad = 0;

   assign ack      = model_en ? ack_mdl : ack_man;
   assign out_flat = dr_out;

   dr_sync_tx #(.WIDTH(8), .SYNC_STAGES(SYNC), .TIMEOUT(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out      (dr_out),
      .ack      (ack),
      .busy     (busy),
      .err      (err)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Receiver model: completion detector raising ack on a full codeword and
   // dropping it on a full spacer; logs each new codeword it sees.
   logic [7:0]  got[$];
   logic [15:0] prev_flat = '0;
   int          adj_err   = 0;
   int          bad_rail  = 0;

   always @(negedge clk) begin
      logic       all_sp, all_ok;
      logic [7:0] w;
      if (model_en) begin
         all_sp = 1'b1;
         all_ok = 1'b1;
         w      = '0;
         for (int i = 0; i < 8; i++) begin
            case (dr_out[i])
               2'b00:   all_ok = 1'b0;
               2'b10:   begin all_sp = 1'b0; w[i] = 1'b1; end
               2'b01:   all_sp = 1'b0;
               default: begin all_sp = 1'b0; all_ok = 1'b0; bad_rail++; end
            endcase
         end
         if (all_ok) ack_mdl = 1'b1;
         else if (all_sp) ack_mdl = 1'b0;
         if (all_ok && out_flat != prev_flat) begin
            if (prev_flat != 16'h0) adj_err++;
            got.push_back(w);
         end
         prev_flat = out_flat;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [7:0]  d;
      logic [15:0] cw;
   } vec_t;

   vec_t       vecs[6];
   logic [7:0] b2b[4];

   initial begin
      int n, idx, early, unstable, stale_bad;
      logic rdy;

      vecs[0] = '{d: 8'hA5, cw: 16'b10_01_10_01_01_10_01_10};
      vecs[1] = '{d: 8'h00, cw: 16'b01_01_01_01_01_01_01_01};
      vecs[2] = '{d: 8'hFF, cw: 16'b10_10_10_10_10_10_10_10};
      vecs[3] = '{d: 8'h3C, cw: 16'b01_01_10_10_10_10_01_01};
      vecs[4] = '{d: 8'hC3, cw: 16'b10_10_01_01_01_01_10_10};
      vecs[5] = '{d: 8'h0F, cw: 16'b01_01_01_01_10_10_10_10};
      b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h3C; b2b[3] = 8'hC3;

      // Reset state
      rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      tick(); tick();
      chk("rst_out", out_flat, 16'h0);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      rst = 1'b0;

      n = 0;
      while (!in_ready && n < 10) begin tick(); n++; end
      chk("post_rst_ready", in_ready, 1'b1);

      // Table: accept, hold codeword against changing in_data, ack, spacer, release
      for (int v = 0; v < 6; v++) begin
         in_data  = vecs[v].d;
         in_valid = 1'b1;
         tick();
         chk("vec_codeword", out_flat, vecs[v].cw);
         chk("vec_busy", busy, 1'b1);
         chk("vec_ready_low", in_ready, 1'b0);
         in_valid = 1'b0;
         in_data  = ~vecs[v].d;
         ack_man  = 1'b1;
         n = 0;
         do begin tick(); n++; end while (out_flat != 16'h0 && n < 8);
         chk("vec_ack_to_spacer", n, SYNC + 1);
         chk("vec_null_busy", busy, 1'b1);
         ack_man = 1'b0;
         n = 0;
         do begin tick(); n++; end while (!in_ready && n < 8);
         chk("vec_release_to_ready", n, SYNC + 1);
         chk("vec_idle_busy", busy, 1'b0);
      end

      // Back-to-back with the receiver model closing the loop
      model_en = 1'b1;
      idx      = 0;
      in_data  = b2b[0];
      in_valid = 1'b1;
      for (int c = 0; c < 200 && idx < 4; c++) begin
         rdy = in_ready;
         tick();
         if (rdy) begin
            idx++;
            if (idx < 4) in_data = b2b[idx];
            else in_valid = 1'b0;
         end
      end
      chk("b2b_all_accepted", idx, 4);
      n = 0;
      while ((busy || ack_mdl) && n < 30) begin tick(); n++; end
      chk("b2b_drained", {busy, ack_mdl}, 2'b00);
      model_en = 1'b0;
      chk("b2b_word_count", got.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < got.size()) chk("b2b_word", got[i], b2b[i]);
      chk("b2b_adjacent_codewords", adj_err, 0);
      chk("b2b_bad_rail", bad_rail, 0);
      chk("b2b_err", err, 1'b0);

      // Stale ack held through reset
      rst = 1'b1; ack_man = 1'b1;
      tick(); tick();
      rst = 1'b0;
      in_data  = 8'h69;
      in_valid = 1'b1;
      stale_bad = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (in_ready !== 1'b0 || out_flat !== 16'h0) stale_bad++;
      end
      chk("stale_held_off", stale_bad, 0);
      chk("stale_no_err", err, 1'b0);
      ack_man = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!in_ready && n < 8);
      chk("stale_release_in_time", (n >= 1 && n <= SYNC + 1), 1'b1);
      tick();
      chk("stale_word_accepted", out_flat, 16'b01_10_10_01_10_01_01_10);
      in_valid = 1'b0;

      // Timeout: no ack, err on the 16th cycle in DATA; in_data churns meanwhile
      early = 0;
      unstable = 0;
      for (int c = 1; c <= 15; c++) begin
         in_data = 8'(c * 37);
         tick();
         if (err) early++;
         if (out_flat !== 16'b01_10_10_01_10_01_01_10) unstable++;
      end
      chk("timeout_not_early", early, 0);
      chk("data_stable_vs_in_data", unstable, 0);
      tick();
      chk("timeout_err_set", err, 1'b1);
      chk("timeout_holds_codeword", out_flat, 16'b01_10_10_01_10_01_01_10);
      tick(); tick(); tick();
      chk("timeout_err_sticky", err, 1'b1);
      ack_man = 1'b1;
      n = 0;
      do begin tick(); n++; end while (out_flat != 16'h0 && n < 8);
      chk("timeout_proceeds_to_null", n, SYNC + 1);
      chk("timeout_null_err", err, 1'b1);
      chk("timeout_null_busy", busy, 1'b1);
      ack_man = 1'b0;
      n = 0;
      do begin tick(); n++; end while (!in_ready && n < 8);
      chk("timeout_back_to_idle", in_ready, 1'b1);

      // Reset mid-transfer
      in_data  = 8'h5A;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("midrst_codeword", out_flat, 16'b01_10_01_10_10_01_10_01);
      rst = 1'b1;
      tick();
      chk("midrst_out", out_flat, 16'h0);
      chk("midrst_in_ready", in_ready, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_err", err, 1'b0);
      rst = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
